// File: rtl/pacman_round_sequencer.sv
// pacman_round_sequencer: Pac-Man round flow FSM (ready/play/dying/clear/win/lose) owning lives, coins, level and score.
// Ports: clk, reset (sync, active-high); startOfFrame, keypadValid, coin_pulse, caught_pulse in;
//        movement_en, respawn, coin_reload, lives, coins_left, level, score, win, lose, state out.
module pacman_round_sequencer #(
  parameter int COINS_PER_LEVEL = 64,
  parameter int START_LIVES = 3,
  parameter int NUM_LEVELS = 3,
  parameter int READY_FRAMES = 60,
  parameter int DEATH_FRAMES = 45,
  parameter int CLEAR_FRAMES = 90,
  localparam int CW = $clog2(COINS_PER_LEVEL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          startOfFrame,
  input  logic          keypadValid,
  input  logic          coin_pulse,
  input  logic          caught_pulse,
  output logic          movement_en,
  output logic          respawn,
  output logic          coin_reload,
  output logic [1:0]    lives,
  output logic [CW-1:0] coins_left,
  output logic [1:0]    level,
  output logic [15:0]   score,
  output logic          win,
  output logic          lose,
  output logic [2:0]    state
);
  localparam int MF = READY_FRAMES > DEATH_FRAMES ? (READY_FRAMES > CLEAR_FRAMES ? READY_FRAMES : CLEAR_FRAMES)
                                                  : (DEATH_FRAMES > CLEAR_FRAMES ? DEATH_FRAMES : CLEAR_FRAMES);
  localparam int FW = $clog2(MF + 1);
  typedef enum logic [2:0] {IDLE, READY, PLAY, DYING, CLEAR, WIN, LOSE} state_t;
  state_t st;
  logic [FW-1:0] frames, limit;
  logic key_q, key_edge, done, coin_ok, last_coin;
  logic [16:0] score_inc;
  logic [15:0] score_next;
  always_comb begin
    limit = st == READY ? FW'(READY_FRAMES - 1) : st == DYING ? FW'(DEATH_FRAMES - 1) : FW'(CLEAR_FRAMES - 1);
    done = startOfFrame && frames == limit;
    key_edge = keypadValid && !key_q;
    coin_ok = coin_pulse && coins_left != '0;
    last_coin = coin_ok && coins_left == CW'(1);
    score_inc = {1'b0, score} + 17'd10;
    score_next = score_inc[16] ? 16'hFFFF : score_inc[15:0];
  end
  assign state = st;
  assign movement_en = st == PLAY;
  assign win = st == WIN;
  assign lose = st == LOSE;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      frames <= '0;
      key_q <= 1'b1;
      respawn <= 1'b0;
      coin_reload <= 1'b0;
      lives <= 2'(START_LIVES);
      level <= '0;
      score <= '0;
      coins_left <= CW'(COINS_PER_LEVEL);
    end else begin
      key_q <= keypadValid;
      respawn <= 1'b0;
      coin_reload <= 1'b0;
      // frames only ever advances in timed states and is zeroed on their exit, so every entry sees zero
      if ((st == READY || st == DYING || st == CLEAR) && startOfFrame) frames <= done ? '0 : frames + FW'(1);
      case (st)
        IDLE: if (key_edge) begin
          st <= READY;
          respawn <= 1'b1;
          coin_reload <= 1'b1;
        end
        READY: if (done) st <= PLAY;
        PLAY: begin
          if (coin_ok) begin
            coins_left <= coins_left - CW'(1);
            score <= score_next;
          end
          // the coin wins a same-cycle tie: clearing the maze spares the life
          if (last_coin) st <= CLEAR;
          else if (caught_pulse) begin
            lives <= lives - 2'd1;
            st <= DYING;
          end
        end
        DYING: if (done) begin
          st <= lives == '0 ? LOSE : READY;
          respawn <= lives != '0;
        end
        CLEAR: if (done) begin
          if (level == 2'(NUM_LEVELS - 1)) st <= WIN;
          else begin
            st <= READY;
            level <= level + 2'd1;
            coins_left <= CW'(COINS_PER_LEVEL);
            respawn <= 1'b1;
            coin_reload <= 1'b1;
          end
        end
        WIN, LOSE: if (key_edge) begin
          st <= IDLE;
          lives <= 2'(START_LIVES);
          level <= '0;
          score <= '0;
          coins_left <= CW'(COINS_PER_LEVEL);
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pacman_round_sequencer.sv
// tb_pacman_round_sequencer: table-driven check of the round sequencer with small test parameters.
module tb_pacman_round_sequencer;
  logic clk = 0, reset = 0, sof = 0, key = 0, coin = 0, caught = 0;
  logic mv, rsp, rld, win, lose;
  logic [1:0] lives, level;
  logic [2:0] coins, st;
  logic [15:0] score;
  int compared = 0, mismatched = 0;

  pacman_round_sequencer #(.COINS_PER_LEVEL(4), .START_LIVES(2), .NUM_LEVELS(2),
    .READY_FRAMES(2), .DEATH_FRAMES(2), .CLEAR_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .keypadValid(key), .coin_pulse(coin),
    .caught_pulse(caught), .movement_en(mv), .respawn(rsp), .coin_reload(rld), .lives(lives),
    .coins_left(coins), .level(level), .score(score), .win(win), .lose(lose), .state(st));

  always #5 clk = ~clk;

  typedef struct {
    logic rst, key, sof, coin, caught;
    logic [2:0] st;
    logic [1:0] lives;
    logic [2:0] coins;
    logic [1:0] lvl;
    logic [15:0] score;
    logic rsp, rld;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(logic r, logic k, logic s, logic c, logic h, int e_st, int e_lv, int e_co,
                             int e_lvl, int e_sc, logic e_rsp, logic e_rld);
    vec_t x;
    x.rst = r; x.key = k; x.sof = s; x.coin = c; x.caught = h;
    x.st = 3'(e_st); x.lives = 2'(e_lv); x.coins = 3'(e_co); x.lvl = 2'(e_lvl); x.score = 16'(e_sc);
    x.rsp = e_rsp; x.rld = e_rld;
    return x;
  endfunction

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(logic r, logic k, logic s, logic c, logic h);
    reset = r; key = k; sof = s; coin = c; caught = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_rsp, n_rld, budget;
    tbl.push_back(v(1,0,0,0,0, 0,2,4,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0, 0,2,4,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,2,4,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0, 1,2,4,0,0,1,1));
    tbl.push_back(v(0,1,1,0,0, 1,2,4,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0, 2,2,4,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0, 2,2,3,0,10,0,0));
    tbl.push_back(v(0,0,0,1,0, 2,2,2,0,20,0,0));
    tbl.push_back(v(0,0,0,0,0, 2,2,2,0,20,0,0));
    tbl.push_back(v(0,0,0,1,0, 2,2,1,0,30,0,0));
    tbl.push_back(v(0,0,0,1,1, 4,2,0,0,40,0,0));
    tbl.push_back(v(0,0,1,0,0, 4,2,0,0,40,0,0));
    tbl.push_back(v(0,0,1,1,1, 1,2,4,1,40,1,1));
    tbl.push_back(v(0,0,1,0,0, 1,2,4,1,40,0,0));
    tbl.push_back(v(0,0,1,0,0, 2,2,4,1,40,0,0));
    tbl.push_back(v(0,0,0,0,1, 3,1,4,1,40,0,0));
    tbl.push_back(v(0,0,1,1,0, 3,1,4,1,40,0,0));
    tbl.push_back(v(0,0,1,0,0, 1,1,4,1,40,1,0));
    tbl.push_back(v(0,0,1,0,0, 1,1,4,1,40,0,0));
    tbl.push_back(v(0,0,1,0,0, 2,1,4,1,40,0,0));
    tbl.push_back(v(0,0,0,1,0, 2,1,3,1,50,0,0));
    tbl.push_back(v(0,0,0,1,1, 3,0,2,1,60,0,0));
    tbl.push_back(v(0,0,1,0,0, 3,0,2,1,60,0,0));
    tbl.push_back(v(0,0,1,0,0, 6,0,2,1,60,0,0));
    tbl.push_back(v(0,0,1,1,1, 6,0,2,1,60,0,0));
    tbl.push_back(v(0,1,0,0,0, 0,2,4,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0, 0,2,4,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,2,4,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0, 1,2,4,0,0,1,1));
    tbl.push_back(v(0,0,1,0,0, 1,2,4,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0, 2,2,4,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 3,1,4,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0, 3,1,4,0,0,0,0));
    tbl.push_back(v(1,0,1,0,0, 0,2,4,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,2,4,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0, 1,2,4,0,0,1,1));
    tbl.push_back(v(0,0,1,0,0, 1,2,4,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0, 2,2,4,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0, 2,2,3,0,10,0,0));
    tbl.push_back(v(0,0,0,1,0, 2,2,2,0,20,0,0));
    tbl.push_back(v(0,0,0,1,0, 2,2,1,0,30,0,0));
    tbl.push_back(v(0,0,1,1,0, 4,2,0,0,40,0,0));
    tbl.push_back(v(0,0,1,0,0, 4,2,0,0,40,0,0));
    tbl.push_back(v(0,0,1,0,0, 1,2,4,1,40,1,1));
    tbl.push_back(v(0,0,1,0,0, 1,2,4,1,40,0,0));
    tbl.push_back(v(0,0,1,0,0, 2,2,4,1,40,0,0));
    tbl.push_back(v(0,0,0,1,0, 2,2,3,1,50,0,0));
    tbl.push_back(v(0,0,0,1,0, 2,2,2,1,60,0,0));
    tbl.push_back(v(0,0,0,1,0, 2,2,1,1,70,0,0));
    tbl.push_back(v(0,1,0,1,0, 4,2,0,1,80,0,0));
    tbl.push_back(v(0,1,1,0,0, 4,2,0,1,80,0,0));
    tbl.push_back(v(0,1,1,0,0, 5,2,0,1,80,0,0));
    tbl.push_back(v(0,1,0,0,0, 5,2,0,1,80,0,0));
    tbl.push_back(v(0,0,0,0,0, 5,2,0,1,80,0,0));
    tbl.push_back(v(0,1,0,0,0, 0,2,4,0,0,0,0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].key, tbl[i].sof, tbl[i].coin, tbl[i].caught);
      chk($sformatf("v%0d.state", i), int'(st), int'(tbl[i].st));
      chk($sformatf("v%0d.lives", i), int'(lives), int'(tbl[i].lives));
      chk($sformatf("v%0d.coins_left", i), int'(coins), int'(tbl[i].coins));
      chk($sformatf("v%0d.level", i), int'(level), int'(tbl[i].lvl));
      chk($sformatf("v%0d.score", i), int'(score), int'(tbl[i].score));
      chk($sformatf("v%0d.respawn", i), int'(rsp), int'(tbl[i].rsp));
      chk($sformatf("v%0d.coin_reload", i), int'(rld), int'(tbl[i].rld));
      chk($sformatf("v%0d.movement_en", i), int'(mv), int'(tbl[i].st == 3'd2));
      chk($sformatf("v%0d.win", i), int'(win), int'(tbl[i].st == 3'd5));
      chk($sformatf("v%0d.lose", i), int'(lose), int'(tbl[i].st == 3'd6));
    end

    // start pulses last exactly one cycle even with the key held and no frames arriving
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_rsp = 0;
    n_rld = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 0);
      n_rsp += int'(rsp);
      n_rld += int'(rld);
    end
    chk("hold.respawn_cycles", n_rsp, 1);
    chk("hold.coin_reload_cycles", n_rld, 1);
    chk("hold.still_ready", int'(st), 1);

    // a frame every cycle must reach PLAY within a small budget
    budget = 0;
    while (st != 3'd2 && budget < 10) begin
      step(0, 0, 1, 0, 0);
      budget++;
    end
    chk("ready_to_play.cycles", budget, 2);
    chk("ready_to_play.movement_en", int'(mv), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
